// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with a fixed 5-cycle (mul) or 10-cycle (div) busy window.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDUResultSel,
    output logic [31:0] MDUResult,
    output logic        busy
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q, hi_n_q, lo_n_q;
    logic        busy_q;
    logic        is_mul, is_div;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, d_s, d_u, q_mag, r_mag, hi_d, lo_d;
    always_comb begin
        is_mul = MDUCtrl == 4'd1 || MDUCtrl == 4'd2;
        is_div = MDUCtrl == 4'd3 || MDUCtrl == 4'd4;
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
        // Signed divide on magnitudes; -2^31 / -1 naturally wraps to 0x80000000
        a_mag  = A[31] ? -A : A;
        b_mag  = B[31] ? -B : B;
        d_s    = B == 32'd0 ? 32'd1 : b_mag;
        d_u    = B == 32'd0 ? 32'd1 : B;
        q_mag  = a_mag / d_s;
        r_mag  = a_mag % d_s;
        hi_d   = MDUCtrl == 4'd1 ? prod_s[63:32] :
                 MDUCtrl == 4'd2 ? prod_u[63:32] :
                 B == 32'd0      ? hi_q :
                 MDUCtrl == 4'd3 ? (A[31] ? -r_mag : r_mag) : A % d_u;
        lo_d   = MDUCtrl == 4'd1 ? prod_s[31:0] :
                 MDUCtrl == 4'd2 ? prod_u[31:0] :
                 B == 32'd0      ? lo_q :
                 MDUCtrl == 4'd3 ? ((A[31] ^ B[31]) ? -q_mag : q_mag) : A / d_u;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
            busy_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start && (is_mul || is_div)) begin
                hi_n_q  <= hi_d;
                lo_n_q  <= lo_d;
                cnt_q   <= is_mul ? 4'd5 : 4'd10;
                state_q <= BUSY;
                busy_q  <= 1'b1;
            end
            if (MDUCtrl == 4'd5) hi_q <= A;
            if (MDUCtrl == 4'd6) lo_q <= A;
        end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_q    <= hi_n_q;
                lo_q    <= lo_n_q;
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end
    assign busy      = busy_q;
    assign MDUResult = MDUResultSel ? lo_q : hi_q;
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: launches mult/multu/div/divu in the current cycle.
REQ-004 SHALL have port MDUCtrl, input, 4 bits: operation select. Encoding: none=0, mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6; values 7-15 treated as none.
REQ-005 SHALL have port A, input, 32 bits: rs operand (multiplicand or dividend; mthi/mtlo source).
REQ-006 SHALL have port B, input, 32 bits: rt operand (multiplier or divisor).
REQ-007 SHALL have port MDUResultSel, input, 1 bit: read select; HI=0, LO=1.
REQ-008 SHALL have port MDUResult, output, 32 bits: selected HI or LO register value.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in flight. The pipeline stalls any md/mt/mf instruction in EX while (start | busy).

Function
REQ-010 SHALL hold architectural registers HI and LO and a shadow result pair (HI_n, LO_n), each 32 bits.
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-012 In IDLE, start=1 with MDUCtrl in {mult, multu}: compute HI_n/LO_n, set cnt=5, go to BUSY.
REQ-013 In IDLE, start=1 with MDUCtrl in {div, divu}: compute HI_n/LO_n, set cnt=10, go to BUSY.
REQ-014 start=1 with any other MDUCtrl value SHALL be ignored; FSM stays in IDLE.
REQ-015 Operands SHALL be sampled only in the start cycle; later changes on A/B SHALL NOT affect the result.
REQ-016 In BUSY, cnt SHALL decrement once per cycle; busy=1 in every BUSY cycle.
REQ-017 When cnt=1, the next edge SHALL copy HI_n/LO_n to HI/LO and return to IDLE.
REQ-018 Timing: with start at cycle T, busy=1 during T+1..T+5 (mult) or T+1..T+10 (div), and new HI/LO are visible at T+6 or T+11 respectively.
REQ-019 busy SHALL be 0 in the start cycle itself.
REQ-020 mult: {HI,LO} = signed(A) * signed(B), full 64 bits. multu: the same product, unsigned.
REQ-021 div: LO = signed quotient truncated toward zero; HI = remainder carrying the dividend's sign.
REQ-022 divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-023 div with A=0x80000000 and B=0xFFFFFFFF SHALL produce LO=0x80000000, HI=0.
REQ-024 div/divu with B=0 SHALL still run the full 10-cycle busy period; HI and LO are then left unchanged.
REQ-025 In IDLE, MDUCtrl=mthi (resp. mtlo) SHALL write A to HI (resp. LO) at the next edge, regardless of start, with no busy period.
REQ-026 In BUSY, start, mthi and mtlo SHALL all be ignored; the in-flight result is committed unaltered.
REQ-027 MDUResult SHALL be combinational: MDUResultSel ? LO : HI, always from the architectural registers. During BUSY it shows the old values.
REQ-028 A new start in the same cycle that BUSY completes (cnt=1) SHALL be ignored; it is accepted on the following cycle when IDLE.

Reset
REQ-029 reset=1 at a clock edge SHALL set HI=0, LO=0, HI_n=0, LO_n=0, cnt=0, state IDLE, busy=0.
REQ-030 Reset SHALL take priority over start and mthi/mtlo in the same cycle.
REQ-031 Reset during BUSY SHALL abort the operation; no partial result is ever committed to HI/LO.

Verification
REQ-032 mult with A=0xFFFFFFFE (-2), B=3 at T -> busy=1 for T+1..T+5; at T+6, HI=0xFFFFFFFF and LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 div with A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF; divu with A=7, B=2 -> LO=3, HI=1.
REQ-034 Set HI=0x11, LO=0x22 via mthi/mtlo, then divu with B=0 -> busy for 10 cycles; HI stays 0x11 and LO stays 0x22; MDUResultSel toggles output between 0x11 and 0x22.
REQ-035 mult started, then A/B changed and mtlo/start issued during busy -> all ignored; product of the originally sampled operands is committed.
REQ-036 div started, reset asserted at busy cycle 4 -> next cycle busy=0, HI=LO=0; a fresh mult then completes normally.
REQ-037 div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; back-to-back start at the completion cycle -> that start is ignored.
